// File: rtl/gf_mult_pkg.sv
// Shared definitions for the GF(2^M) multiplier arbiter: field width,
// controller state encoding and timeout-timer width.
package gf_mult_pkg;

  localparam int M       = 163;
  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } state_t;

  typedef logic [TIMER_W-1:0] timer_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr,
// wrapping at N_REQ-1, wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output gets a default before the loop so no path infers a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/gf_mult_arbiter.sv
// Shares one GF(2^M) multiplier among N_REQ requesters: round-robin grant,
// run with a timeout, then a one-cycle response and multiplier re-arm.
module gf_mult_arbiter
  import gf_mult_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int M       = gf_mult_pkg::M,
  parameter int TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*M-1:0] req_a,
  input  logic [N_REQ*M-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [M-1:0]       rsp_z,
  output logic               rsp_err,
  output logic [M-1:0]       mult_a,
  output logic [M-1:0]       mult_b,
  output logic               mult_start,
  output logic               mult_rst,
  input  logic [M-1:0]       mult_z,
  input  logic               mult_done,
  output logic               busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  timer_t           timer;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic             mult_rst_q;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic [M-1:0]     sel_a;
  logic [M-1:0]     sel_b;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_a = req_a[i*M +: M];
        sel_b = req_b[i*M +: M];
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      ptr        <= '0;
      gidx       <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_z      <= '0;
      rsp_err    <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      mult_start <= 1'b0;
      mult_rst_q <= 1'b0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      mult_rst_q <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            req_ready  <= arb_grant;
            mult_a     <= sel_a;
            mult_b     <= sel_b;
            gidx       <= arb_idx;
            ptr        <= (arb_idx == IDX_W'(N_REQ-1)) ? '0 : arb_idx + IDX_W'(1);
            timer      <= '0;
            mult_start <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          timer <= timer + timer_t'(1);
          // A completion in the last timer cycle still counts as success.
          if (mult_done) begin
            rsp_z      <= mult_z;
            rsp_valid  <= N_REQ'(1) << gidx;
            mult_start <= 1'b0;
            mult_rst_q <= 1'b1;
            state      <= RESP;
          end else if (timer == timer_t'(TIMEOUT-1)) begin
            rsp_z      <= '0;
            rsp_valid  <= N_REQ'(1) << gidx;
            rsp_err    <= 1'b1;
            mult_start <= 1'b0;
            mult_rst_q <= 1'b1;
            state      <= ABORT;
          end
        end
        RESP, ABORT: state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  // The multiplier's done flag only clears on reset, so hold it in reset
  // whenever this block is in reset, not just during the re-arm cycle.
  assign mult_rst = !rst_n || mult_rst_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// Self-checking bench: a per-cycle timeline model of each operation plus a
// GF(2^163) multiplier model, driven with directed and random requests.
module tb_gf_mult_arbiter;

  localparam int N  = 4;
  localparam int MW = 163;
  localparam int TO = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*MW-1:0] req_a, req_b;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [MW-1:0]   rsp_z, mult_a, mult_b, mult_z;
  logic            rsp_err, mult_start, mult_rst, mult_done, busy;

  always #5 clk = ~clk;

  gf_mult_arbiter #(.N_REQ(N), .M(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_err(rsp_err),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start), .mult_rst(mult_rst),
    .mult_z(mult_z), .mult_done(mult_done), .busy(busy)
  );

  logic [MW-1:0] op_a [N];
  logic [MW-1:0] op_b [N];

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*MW +: MW] = op_a[i];
      req_b[i*MW +: MW] = op_b[i];
    end
  end

  int n_checks, n_err;

  // Operation timeline model: m_t counts cycles since the grant edge.
  bit            m_active;
  int            m_t, m_g, m_done_at, m_resp_at, m_ptr, ops_done;
  bit            m_err;
  logic [MW-1:0] m_a, m_b;

  int       done_mode, fixed_lat, reset_at_t;
  logic [N-1:0] hold_mask;
  bit       auto_new, stray;

  int            grant_q[$], rsp_q[$];
  logic [MW-1:0] last_z;
  logic          last_err;
  int            start_cnt, mrst_cnt;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Polynomial product reduced by x^163 + x^7 + x^6 + x^3 + 1.
  function automatic logic [MW-1:0] gf_mul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW:0]   sh, red;
    logic [MW-1:0] r;
    red = '0;
    red[MW] = 1'b1;
    red[7:0] = 8'hC9;
    sh = {1'b0, a};
    r = '0;
    for (int i = 0; i < MW; i++) begin
      if (b[i]) r ^= sh[MW-1:0];
      sh = sh << 1;
      if (sh[MW]) sh ^= red;
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_wide();
    logic [MW-1:0] v;
    v = '0;
    for (int i = 0; i < MW; i += 32) v = (v << 32) | MW'($urandom);
    return v;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick();
    for (int k = 0; k < N; k++) if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic int pick_done();
    int r;
    case (done_mode)
      1: return fixed_lat;
      2: return 0;
      3: return int'($urandom_range(1, 30));
      default: begin
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return TO;
        if (r == 2) return TO + 1;
        return int'($urandom_range(1, 30));
      end
    endcase
  endfunction

  task automatic compare();
    logic         in_resp;
    logic [N-1:0] e_ready, e_rsp;
    in_resp = m_active && (m_t == m_resp_at);
    e_ready = (m_active && m_t == 1) ? (N'(1) << m_g) : '0;
    e_rsp   = in_resp ? (N'(1) << m_g) : '0;
    check("busy", busy, m_active);
    check("req_ready", req_ready, e_ready);
    check("rsp_valid", rsp_valid, e_rsp);
    check("mult_start", mult_start, m_active && !in_resp);
    check("mult_rst", mult_rst, in_resp);
    if (m_active) begin
      check("mult_a", mult_a, m_a);
      check("mult_b", mult_b, m_b);
    end
    if (in_resp) begin
      check("rsp_err", rsp_err, m_err);
      check("rsp_z", rsp_z, m_err ? '0 : gf_mul(m_a, m_b));
    end
    if (req_ready != '0) grant_q.push_back(onehot_idx(req_ready));
    if (rsp_valid != '0) begin
      rsp_q.push_back(onehot_idx(rsp_valid));
      last_z   = rsp_z;
      last_err = rsp_err;
    end
    if (mult_start) start_cnt++;
    if (mult_rst) mrst_cnt++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_z"}, rsp_z, 0);
    check({tag, "_mult_a"}, mult_a, 0);
    check({tag, "_mult_b"}, mult_b, 0);
    check({tag, "_mult_start"}, mult_start, 0);
    check({tag, "_mult_rst"}, mult_rst, 1);
  endtask

  task automatic model_clear();
    m_active = 1'b0;
    m_t = 0;
    m_ptr = 0;
    ops_done = 0;
    grant_q.delete();
    rsp_q.delete();
    start_cnt = 0;
    mrst_cnt = 0;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    mult_done = 1'b0;
    hold_mask = '0;
    auto_new  = 1'b0;
    stray     = 1'b0;
    rst_n     = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_reset_outputs("rst");
    end
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mid_reset();
    rst_n = 1'b0;
    mult_done = 1'b0;
    #1;
    check_reset_outputs("mid_rst_async");
    @(negedge clk);
    check_reset_outputs("mid_rst_held");
    rst_n = 1'b1;
    m_active = 1'b0;
    m_ptr = 0;
    reset_at_t = 0;
    @(posedge clk);
    #1;
  endtask

  // One clock: check this cycle, set inputs for the coming edge, advance model.
  task automatic cycle();
    @(negedge clk);
    compare();
    if (m_active && reset_at_t != 0 && m_t == reset_at_t) begin
      do_mid_reset();
      return;
    end
    if (m_active && m_t == 1) begin
      if (hold_mask[m_g]) begin
        op_a[m_g] = rand_wide();
        op_b[m_g] = rand_wide();
      end else begin
        req_valid[m_g] = 1'b0;
      end
    end
    if (auto_new)
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
          op_a[i] = rand_wide();
          op_b[i] = rand_wide();
          req_valid[i] = 1'b1;
        end
    mult_done = m_active && (m_t == m_done_at);
    if (!mult_done && stray && (!m_active || m_t == m_resp_at) && $urandom_range(0, 7) == 0)
      mult_done = 1'b1;
    mult_z = mult_done ? gf_mul(mult_a, mult_b) : rand_wide();
    if (m_active) begin
      if (m_t == m_resp_at) begin
        m_active = 1'b0;
        ops_done++;
      end else begin
        m_t++;
      end
    end else if (req_valid != '0) begin
      m_g       = rr_pick();
      m_ptr     = (m_g + 1) % N;
      m_a       = op_a[m_g];
      m_b       = op_b[m_g];
      m_done_at = pick_done();
      m_err     = !(m_done_at >= 1 && m_done_at <= TO);
      m_resp_at = m_err ? TO + 1 : m_done_at + 1;
      m_active  = 1'b1;
      m_t       = 1;
    end
  endtask

  task automatic run_ops(input string name, input int n, input int budget);
    int c, start;
    c = 0;
    start = ops_done;
    while (ops_done - start < n && c < budget) begin
      cycle();
      c++;
    end
    check({name, "_ops_completed"}, ops_done - start, n);
  endtask

  task automatic settle();
    req_valid = '0;
    hold_mask = '0;
    auto_new  = 1'b0;
    stray     = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic check_q(input string name, input int q[$], input int exp[$]);
    check({name, "_count"}, q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q.size(); i++) check(name, q[i], exp[i]);
  endtask

  initial begin
    int e[$];
    n_checks = 0;
    n_err = 0;
    done_mode = 0;
    fixed_lat = 1;
    reset_at_t = 0;
    req_valid = '0;
    mult_done = 1'b0;
    mult_z = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    model_clear();

    // Pin the multiplier model with hand-computed products.
    check("model_gf_1x2", gf_mul(MW'(1), MW'(2)), MW'(2));
    check("model_gf_3x3", gf_mul(MW'(3), MW'(3)), MW'(5));
    check("model_gf_wrap", gf_mul(MW'(1) << (MW-1), MW'(2)), MW'('hC9));

    apply_reset();

    // Single request from requester 1 at the multiplier's native latency.
    op_a[1] = MW'(1);
    op_b[1] = MW'(2);
    done_mode = 1;
    fixed_lat = MW + 3;
    req_valid = 4'b0010;
    run_ops("single", 1, 400);
    e = {1};
    check_q("single_grant", grant_q, e);
    check_q("single_rsp", rsp_q, e);
    check("single_rsp_z", last_z, MW'(2));
    check("single_rsp_err", last_err, 0);
    check("single_mult_rst_pulses", mrst_cnt, 1);
    settle();

    // Two requesters held: alternate 0, 2, 0, 2.
    apply_reset();
    done_mode = 3;
    for (int i = 0; i < N; i++) begin
      op_a[i] = rand_wide();
      op_b[i] = rand_wide();
    end
    hold_mask = 4'b0101;
    req_valid = 4'b0101;
    run_ops("pair", 4, 400);
    e = {0, 2, 0, 2};
    check_q("pair_grant", grant_q, e);
    check_q("pair_rsp", rsp_q, e);
    settle();

    // All four held for eight operations, pointer wraps.
    apply_reset();
    hold_mask = 4'b1111;
    req_valid = 4'b1111;
    run_ops("all", 8, 800);
    e = {0, 1, 2, 3, 0, 1, 2, 3};
    check_q("all_grant", grant_q, e);
    check_q("all_rsp", rsp_q, e);
    settle();

    // Multiplier never completes: abort after TIMEOUT RUN cycles.
    apply_reset();
    done_mode = 2;
    op_a[3] = rand_wide();
    op_b[3] = rand_wide();
    req_valid = 4'b1000;
    run_ops("timeout", 1, 400);
    check("timeout_run_cycles", start_cnt, TO);
    check("timeout_rsp_err", last_err, 1);
    check("timeout_rsp_z", last_z, 0);
    e = {3};
    check_q("timeout_rsp", rsp_q, e);
    settle();

    // Completion in the very cycle the timer expires wins over the timeout.
    apply_reset();
    done_mode = 1;
    fixed_lat = TO;
    op_a[0] = MW'(3);
    op_b[0] = MW'(3);
    req_valid = 4'b0001;
    run_ops("race", 1, 400);
    check("race_run_cycles", start_cnt, TO);
    check("race_rsp_err", last_err, 0);
    check("race_rsp_z", last_z, MW'(5));
    settle();

    // Reset 50 cycles into RUN, then a normal operation from pointer 0.
    apply_reset();
    done_mode = 2;
    reset_at_t = 50;
    op_a[1] = rand_wide();
    op_b[1] = rand_wide();
    req_valid = 4'b0010;
    for (int c = 0; c < 100 && reset_at_t != 0; c++) cycle();
    check("midrst_reached", reset_at_t, 0);
    done_mode = 3;
    op_a[2] = rand_wide();
    op_b[2] = rand_wide();
    req_valid = 4'b0110;
    run_ops("after_rst", 1, 100);
    e = {1, 1};
    check_q("after_rst_grant", grant_q, e);
    e = {1};
    check_q("after_rst_rsp", rsp_q, e);
    settle();

    // Random traffic with stray completions outside RUN.
    apply_reset();
    done_mode = 0;
    auto_new = 1'b1;
    stray = 1'b1;
    run_ops("random", 40, 20000);
    settle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
